// File: rtl/rv32_alu_ctrl_stage.sv
// RV32I ALU-control decode stage with a 2-entry skid buffer on the output handshake.
// Optional strict legality checking is enabled by defining ALU_CTRL_ILLEGAL_EN.
module rv32_alu_ctrl_stage #(
   parameter int unsigned TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alufn,
   output logic             out_src_a_pc,
   output logic             out_src_b_imm,
   output logic             out_shamt_imm,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [3:0] AluAdd   = 4'b0000;
   localparam logic [3:0] AluSub   = 4'b0001;
   localparam logic [3:0] AluPassB = 4'b0011;
   localparam logic [3:0] AluOr    = 4'b0100;
   localparam logic [3:0] AluAnd   = 4'b0101;
   localparam logic [3:0] AluXor   = 4'b0111;
   localparam logic [3:0] AluSrl   = 4'b1000;
   localparam logic [3:0] AluSll   = 4'b1001;
   localparam logic [3:0] AluSra   = 4'b1010;
   localparam logic [3:0] AluSlt   = 4'b1101;
   localparam logic [3:0] AluSltu  = 4'b1111;

   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpFence  = 7'b0001111;
   localparam logic [6:0] OpSystem = 7'b1110011;
   localparam logic [6:0] F7Alt    = 7'b0100000;

   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOne   = 2'd1;
   localparam logic [1:0] StTwo   = 2'd2;

   localparam int unsigned PW = TAG_W + 8;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_instr;

   assign opcode       = in_instr[6:0];
   assign funct3       = in_instr[14:12];
   assign funct7       = in_instr[31:25];
   assign unused_instr = ^{in_instr[24:15], in_instr[11:7]};

   logic [3:0] dec_alufn;
   logic       dec_a_pc;
   logic       dec_b_imm;
   logic       dec_shamt;
   logic       dec_ill;

`ifdef ALU_CTRL_ILLEGAL_EN
   always_comb begin
      dec_ill = 1'b0;
      case (opcode)
         OpReg: begin
            if (funct7 == F7Alt) begin
               dec_ill = !(funct3 == 3'b000 || funct3 == 3'b101);
            end else begin
               dec_ill = (funct7 != 7'b0000000);
            end
         end
         OpImm: begin
            if (funct3 == 3'b001) begin
               dec_ill = (funct7 != 7'b0000000);
            end else if (funct3 == 3'b101) begin
               dec_ill = (funct7 != 7'b0000000) && (funct7 != F7Alt);
            end
         end
         OpLui, OpAuipc, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpFence, OpSystem: ;
         default: dec_ill = 1'b1;
      endcase
   end
`else
   assign dec_ill = 1'b0;
`endif

   always_comb begin
      dec_alufn = AluAdd;
      dec_a_pc  = 1'b0;
      dec_b_imm = 1'b0;
      dec_shamt = 1'b0;
      case (opcode)
         OpReg, OpImm: begin
            case (funct3)
               3'b000: dec_alufn = (opcode == OpReg && funct7 == F7Alt) ? AluSub : AluAdd;
               3'b001: dec_alufn = AluSll;
               3'b010: dec_alufn = AluSlt;
               3'b011: dec_alufn = AluSltu;
               3'b100: dec_alufn = AluXor;
               3'b101: dec_alufn = (funct7 == F7Alt) ? AluSra : AluSrl;
               3'b110: dec_alufn = AluOr;
               3'b111: dec_alufn = AluAnd;
            endcase
            if (opcode == OpImm) begin
               dec_b_imm = 1'b1;
               dec_shamt = (funct3[1:0] == 2'b01);
            end
         end
         OpLui: begin
            dec_alufn = AluPassB;
            dec_b_imm = 1'b1;
         end
         OpAuipc: begin
            dec_a_pc  = 1'b1;
            dec_b_imm = 1'b1;
         end
         OpLoad, OpStore: dec_b_imm = 1'b1;
         OpBranch:        dec_alufn = AluSub;
         OpJal, OpJalr:   dec_a_pc  = 1'b1;
         OpFence, OpSystem: dec_alufn = AluAdd;
         default: ;
      endcase
`ifdef ALU_CTRL_ILLEGAL_EN
      if (dec_ill) begin
         dec_alufn = AluAdd;
         dec_a_pc  = 1'b0;
         dec_b_imm = 1'b0;
         dec_shamt = 1'b0;
      end
`endif
   end

   // Payload layout: {tag, illegal, shamt_imm, src_b_imm, src_a_pc, alufn}
   logic [PW-1:0] dec_pl;
   assign dec_pl = {in_tag, dec_ill, dec_shamt, dec_b_imm, dec_a_pc, dec_alufn};

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] main_q, main_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          accept;

   assign in_ready  = (state_q != StTwo);
   assign out_valid = (state_q != StEmpty);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  main_d  = dec_pl;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && out_ready) begin
                  main_d = dec_pl;
               end else if (accept) begin
                  skid_d  = dec_pl;
                  state_d = StTwo;
               end else if (out_ready) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_ready) begin
                  main_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign out_alufn     = main_q[3:0];
   assign out_src_a_pc  = main_q[4];
   assign out_src_b_imm = main_q[5];
   assign out_shamt_imm = main_q[6];
   assign out_illegal   = main_q[7];
   assign out_tag       = main_q[PW-1:8];

endmodule

// File: tb/tb_rv32_alu_ctrl_stage.sv
// Randomized bench for rv32_alu_ctrl_stage: FIFO scoreboard plus a table-driven decode model.
// Build with ALU_CTRL_ILLEGAL_EN defined to check the strict-legality variant.
module tb_rv32_alu_ctrl_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alufn;
   logic        out_src_a_pc;
   logic        out_src_b_imm;
   logic        out_shamt_imm;
   logic        out_illegal;
   logic [31:0] out_tag;

   int n_total;
   int n_bad;

`ifdef ALU_CTRL_ILLEGAL_EN
   localparam bit IllEn = 1'b1;
`else
   localparam bit IllEn = 1'b0;
`endif

   // Operation by funct3, index 7 down to 0: AND OR SRL XOR SLTU SLT SLL ADD
   localparam logic [7:0][3:0] F3Op = {4'b0101, 4'b0100, 4'b1000, 4'b0111,
                                       4'b1111, 4'b1101, 4'b1001, 4'b0000};

   typedef struct packed {
      logic [3:0]  alufn;
      logic        a_pc;
      logic        b_imm;
      logic        shamt;
      logic        ill;
      logic [31:0] tag;
   } exp_t;

   exp_t q[$];

   rv32_alu_ctrl_stage #(.TAG_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_tag        (in_tag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_alufn     (out_alufn),
      .out_src_a_pc  (out_src_a_pc),
      .out_src_b_imm (out_src_b_imm),
      .out_shamt_imm (out_shamt_imm),
      .out_illegal   (out_illegal),
      .out_tag       (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] tag);
      exp_t       e;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       illegal;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      e = '0;
      e.tag = tag;
      illegal = 1'b0;
      case (opc)
         7'b0110011: begin
            e.alufn = F3Op[f3];
            if (f7 == 7'h20 && f3 == 3'd0) e.alufn = 4'b0001;
            if (f7 == 7'h20 && f3 == 3'd5) e.alufn = 4'b1010;
            illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'b0010011: begin
            e.b_imm = 1'b1;
            e.alufn = F3Op[f3];
            if (f3 == 3'd5 && f7 == 7'h20) e.alufn = 4'b1010;
            e.shamt = (f3 == 3'd1 || f3 == 3'd5);
            illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
         end
         7'b0110111: begin e.alufn = 4'b0011; e.b_imm = 1'b1; end
         7'b0010111: begin e.a_pc = 1'b1; e.b_imm = 1'b1; end
         7'b0000011, 7'b0100011: e.b_imm = 1'b1;
         7'b1100011: e.alufn = 4'b0001;
         7'b1101111, 7'b1100111: e.a_pc = 1'b1;
         7'b0001111, 7'b1110011: ;
         default: illegal = 1'b1;
      endcase
      if (illegal && IllEn) begin
         e.alufn = 4'b0000;
         e.a_pc  = 1'b0;
         e.b_imm = 1'b0;
         e.shamt = 1'b0;
         e.ill   = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         2: f7 = 7'h01;
         default: f7 = r[31:25];
      endcase
      case ($urandom_range(0, 12))
         0:      begin r[6:0] = 7'b0110011; r[31:25] = f7; end
         1, 2:   begin r[6:0] = 7'b0010011; r[31:25] = f7; end
         3:      r[6:0] = 7'b0110111;
         4:      r[6:0] = 7'b0010111;
         5:      r[6:0] = 7'b0000011;
         6:      r[6:0] = 7'b0100011;
         7:      r[6:0] = 7'b1100011;
         8:      r[6:0] = 7'b1101111;
         9:      r[6:0] = 7'b1100111;
         10:     r[6:0] = 7'b0001111;
         11:     r[6:0] = 7'b1110011;
         default: ;
      endcase
      return r;
   endfunction

   task automatic check_outputs();
      check_eq("in_ready", in_ready, q.size() < 2);
      check_eq("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
         check_eq("alufn", out_alufn, q[0].alufn);
         check_eq("selects", {out_src_a_pc, out_src_b_imm, out_shamt_imm, out_illegal},
                  {q[0].a_pc, q[0].b_imm, q[0].shamt, q[0].ill});
         check_eq("tag", out_tag, q[0].tag);
      end
   endtask

   // One clock: check at negedge, drive, then advance the scoreboard at posedge.
   task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] tag,
                       input logic ordy, input logic fl);
      logic fire_in;
      logic fire_out;
      @(negedge clk);
      check_outputs();
      in_valid  = v;
      in_instr  = instr;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      fire_in   = v && (q.size() < 2) && !fl;
      fire_out  = ordy && (q.size() > 0);
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (fire_out) void'(q.pop_front());
         if (fire_in) q.push_back(ref_decode(instr, tag));
      end
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      #12;
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_payload", {out_alufn, out_src_a_pc, out_src_b_imm, out_shamt_imm,
                               out_illegal, out_tag}, 40'h0);
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 32'h40B50533, 32'h10, 1'b1, 1'b0);
      #1;
      check_eq("sub_valid", out_valid, 1'b1);
      check_eq("sub_alufn", out_alufn, 4'b0001);
      check_eq("sub_bimm", out_src_b_imm, 1'b0);
      check_eq("sub_ill", out_illegal, 1'b0);

      step(1'b1, 32'h40335293, 32'h14, 1'b1, 1'b0);
      #1;
      check_eq("srai_alufn", out_alufn, 4'b1010);
      check_eq("srai_sel", {out_src_b_imm, out_shamt_imm}, 2'b11);
      step(1'b1, 32'h123450B7, 32'h18, 1'b1, 1'b0);
      #1;
      check_eq("lui_alufn", out_alufn, 4'b0011);
      check_eq("lui_bimm", out_src_b_imm, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
      step(1'b1, 32'h0020A113, 32'h104, 1'b0, 1'b0);
      #1;
      check_eq("two_in_ready", in_ready, 1'b0);
      check_eq("two_head_tag", out_tag, 32'h100);
      check_eq("two_head_alufn", out_alufn, 4'b0000);
      step(1'b1, 32'h0020B193, 32'h108, 1'b0, 1'b0);
      step(1'b1, 32'h0020B193, 32'h108, 1'b1, 1'b0);
      #1;
      check_eq("pop1_tag", out_tag, 32'h104);
      check_eq("pop1_alufn", out_alufn, 4'b1101);
      step(1'b1, 32'h0020B193, 32'h108, 1'b1, 1'b0);
      #1;
      check_eq("pop2_tag", out_tag, 32'h108);
      check_eq("pop2_alufn", out_alufn, 4'b1111);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      step(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0);
      step(1'b1, 32'h0020A113, 32'h204, 1'b0, 1'b0);
      step(1'b1, 32'h0020B193, 32'h208, 1'b0, 1'b1);
      #1;
      check_eq("flush_valid", out_valid, 1'b0);
      check_eq("flush_ready", in_ready, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      step(1'b1, 32'h02B50533, 32'h300, 1'b1, 1'b0);
      #1;
      check_eq("mul_alufn", out_alufn, 4'b0000);
      check_eq("mul_ill", out_illegal, IllEn);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      step(1'b1, 32'h00500093, 32'h380, 1'b0, 1'b0);
      step(1'b1, 32'h0020A113, 32'h384, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", out_valid, 1'b0);
      check_eq("arst_ready", in_ready, 1'b1);
      check_eq("arst_payload", {out_alufn, out_src_a_pc, out_src_b_imm, out_shamt_imm,
                                out_illegal, out_tag}, 40'h0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 32'h00C5F533, 32'h400, 1'b1, 1'b0);
      #1;
      check_eq("and_alufn", out_alufn, 4'b0101);
      check_eq("and_tag", out_tag, 32'h400);

      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, gen_instr(), $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      check_outputs();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rv32_alu_ctrl_stage.md
Name: rv32_alu_ctrl_stage

Overview:
- Decode/issue stage that generates the 4-bit alufn code and operand-select controls consumed by the execute-stage ALU.
- Decodes one RV32I instruction per accepted transfer.
- Registers the result behind a valid/ready handshake with a 2-deep skid buffer, so ALU-side backpressure never creates a combinational path to the fetch side.
- Sits between the ID/EX boundary and the ALU/operand muxes.

Parameters:
- TAG_W, 32, width of the opaque tag (typically PC) carried alongside each instruction.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  instruction valid
- in_ready  output  1  stage can accept
- in_instr  input  32  raw RV32I instruction
- in_tag  input  TAG_W  pass-through tag
- out_valid  output  1  decoded entry valid
- out_ready  input  1  ALU side accepts
- out_alufn  output  4  ALU function code
- out_src_a_pc  output  1  operand A = PC (AUIPC, JAL, JALR)
- out_src_b_imm  output  1  operand B = immediate
- out_shamt_imm  output  1  shamt from instr[24:20], else rs2[4:0]
- out_illegal  output  1  unsupported encoding
- out_tag  output  TAG_W  tag of the presented entry

Behaviour:
- alufn codes:
  - 0000 ADD, 0001 SUB, 0011 PASS_B
  - 0100 OR, 0101 AND, 0111 XOR
  - 1000 SRL, 1001 SLL, 1010 SRA
  - 1101 SLT, 1111 SLTU
- R-type (0110011) and I-ALU (0010011), decoded by funct3:
  - 000 ADD; SUB only for R-type with funct7=0100000
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101 SRL (funct7=0000000) / SRA (funct7=0100000)
  - 110 OR, 111 AND
- Operand selects for R/I types:
  - I-ALU: src_b_imm=1.
  - I-type shifts: shamt_imm=1.
- Other opcodes:
  - LUI 0110111: PASS_B, src_b_imm=1.
  - AUIPC 0010111: ADD, src_a_pc=1, src_b_imm=1.
  - LOAD 0000011 and STORE 0100011: ADD, src_b_imm=1.
  - BRANCH 1100011: SUB (flags only), src_b_imm=0.
  - JAL 1101111 and JALR 1100111: ADD, src_a_pc=1.
  - FENCE and SYSTEM: ADD, all selects 0, legal.
- Handshake:
  - A transfer occurs on valid&&ready at a clock edge.
  - Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N.
- Buffer: a main register plus a skid register; state is EMPTY, ONE or TWO.
  - EMPTY: in_ready=1, out_valid=0. On accept, go to ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept with out_ready: main is replaced, stay ONE.
    - Accept without out_ready: new entry goes to skid, go to TWO.
    - out_ready without accept: go to EMPTY.
  - TWO: in_ready=0, out_valid=1. On out_ready, skid moves to main, go to ONE.
- Ordering is strictly FIFO. The tag always travels with its decode.
- Outputs are driven only from registers; in_ready depends only on state.
- flush has priority over every other event:
  - Next state is EMPTY; any concurrent input is dropped.
  - out_valid=0 and in_ready=1 in the next cycle.
- Reset drives state EMPTY and every output 0 except in_ready, which is 1.
  - Reset asserted mid-transfer discards all entries.
- out_* payload holds stable while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- Defined: out_illegal=1 for any of:
  - unknown opcode
  - R-type funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101
  - I-type shift with bad funct7
  - When out_illegal=1, alufn=0000 and all selects are 0.
- Undefined: out_illegal is tied 0. Unknown encodings decode to ADD with all selects 0.

Test Plan:
- 0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle out_valid=1, alufn=0001, src_b_imm=0, illegal=0.
- 0x40335293 (srai t0,t1,3) -> alufn=1010, src_b_imm=1, shamt_imm=1. Then 0x123450B7 (lui) -> alufn=0011, src_b_imm=1.
- Back-to-back 0x00500093 (tag 0x100), 0x0020A113 (tag 0x104), 0x0020B193 (tag 0x108) with out_ready=0:
  - in_ready drops after the second accept.
  - Raising out_ready yields in order: tag 0x100 alufn 0000, tag 0x104 alufn 1101, tag 0x108 alufn 1111.
- In state TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; no entry ever emerges.
- With ALU_CTRL_ILLEGAL_EN: 0x02B50533 (mul) -> illegal=1, alufn=0000. Without the macro -> illegal=0, alufn=0000.
- Assert rst while in state TWO -> outputs immediately 0 and in_ready=1 (asynchronous). After deassert, the first accepted 0x00C5F533 (and) presents alufn=0101.
